// File: rtl/mlp_engine.sv
// Time-multiplexed two-layer perceptron with run-time loadable weights/biases and incremental argmax.
// Optional macro MLP_ROUND_EN: round half up in the hidden-layer requantisation instead of truncating.
module mlp_engine #(
    parameter int N_IN  = 62,
    parameter int N_HID = 30,
    parameter int N_OUT = 10,
    parameter int DW    = 8,
    parameter int N_PU  = 8,
    parameter int SHIFT = 7,
    localparam int AW   = $clog2((N_IN*N_HID > N_HID*N_OUT) ? N_IN*N_HID : N_HID*N_OUT),
    localparam int RW   = $clog2(N_OUT)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [N_IN*DW-1:0] input_data,
    input  logic               wr_en,
    input  logic [1:0]         wr_sel,
    input  logic [AW-1:0]      wr_addr,
    input  logic [DW-1:0]      wr_data,
    output logic               busy,
    output logic               finish,
    output logic [RW-1:0]      model_result,
    output logic [2:0]         dbg_state
);
    localparam int K1    = (N_IN + N_PU - 1) / N_PU;
    localparam int K2    = (N_HID + N_PU - 1) / N_PU;
    localparam int ACC_W = 2*DW + $clog2((N_IN > N_HID) ? N_IN : N_HID) + 1;
    localparam int PW    = ACC_W + 2;
    localparam int SW    = ACC_W + 1;
    localparam int W1N   = N_IN * N_HID;
    localparam int W2N   = N_HID * N_OUT;
    localparam int W1AW  = $clog2(W1N);
    localparam int W2AW  = $clog2(W2N);
    localparam int XIW   = $clog2(N_IN);
    localparam int HIW   = $clog2(N_HID);
    localparam int CW    = $clog2((N_HID > N_OUT) ? N_HID : N_OUT);
    localparam int KW    = $clog2(((K1 > K2) ? K1 : K2) + 1);

    localparam logic [KW-1:0]        K1_LAST  = KW'(K1 - 1);
    localparam logic [KW-1:0]        K2_LAST  = KW'(K2 - 1);
    localparam logic [CW-1:0]        HID_LAST = CW'(N_HID - 1);
    localparam logic [CW-1:0]        OUT_LAST = CW'(N_OUT - 1);
    localparam logic signed [PW-1:0] H_MAX    = PW'((1 << (DW - 1)) - 1);
`ifdef MLP_ROUND_EN
    localparam logic signed [PW-1:0] RND      = (SHIFT > 0) ? (PW'(1) <<< (SHIFT - 1)) : '0;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_L1_MAC, S_L1_WB, S_L2_MAC, S_L2_WB, S_DONE
    } state_t;

    state_t                    r_state;
    logic [KW-1:0]             r_k;
    logic [CW-1:0]             r_n;
    logic signed [ACC_W-1:0]   r_acc;
    logic signed [SW-1:0]      r_best;
    logic [RW-1:0]             r_best_idx;
    logic                      r_busy;
    logic                      r_finish;
    logic [RW-1:0]             r_result;

    logic signed [DW-1:0]      r_w1 [W1N];
    logic signed [DW-1:0]      r_b1 [N_HID];
    logic signed [DW-1:0]      r_w2 [W2N];
    logic signed [DW-1:0]      r_b2 [N_OUT];
    logic signed [DW-1:0]      r_x  [N_IN];
    logic signed [DW-1:0]      r_h  [N_HID];

    logic signed [2*DW-1:0]    w_prod [N_PU];
    logic signed [ACC_W-1:0]   w_sum;
    logic signed [PW-1:0]      w_pre;
    logic signed [PW-1:0]      w_shr;
    logic signed [DW-1:0]      w_hq;
    logic signed [SW-1:0]      w_score;

    assign busy         = r_busy;
    assign finish       = r_finish;
    assign model_result = r_result;
    assign dbg_state    = r_state;

    // Parameter memories have no reset; writes land only while idle and only inside each memory's depth.
    always_ff @(posedge clk) begin
        if (wr_en && r_state == S_IDLE) begin
            case (wr_sel)
                2'd0:    if (int'(wr_addr) < W1N)   r_w1[wr_addr[W1AW-1:0]] <= wr_data;
                2'd1:    if (int'(wr_addr) < N_HID) r_b1[wr_addr[HIW-1:0]]  <= wr_data;
                2'd2:    if (int'(wr_addr) < W2N)   r_w2[wr_addr[W2AW-1:0]] <= wr_data;
                default: if (int'(wr_addr) < N_OUT) r_b2[wr_addr[RW-1:0]]   <= wr_data;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && start) begin
            for (int i = 0; i < N_IN; i++) r_x[i] <= input_data[i*DW +: DW];
        end
        if (r_state == S_L1_WB) r_h[r_n[HIW-1:0]] <= w_hq;
    end

    // One chunk of N_PU lanes per MAC cycle; lanes past the layer width contribute nothing.
    always_comb begin
        w_sum = '0;
        for (int j = 0; j < N_PU; j++) begin
            w_prod[j] = '0;
            if (r_state == S_L1_MAC && (int'(r_k) * N_PU + j) < N_IN) begin
                w_prod[j] = r_x[XIW'(int'(r_k) * N_PU + j)]
                          * r_w1[W1AW'(int'(r_n) * N_IN + int'(r_k) * N_PU + j)];
            end else if (r_state == S_L2_MAC && (int'(r_k) * N_PU + j) < N_HID) begin
                w_prod[j] = r_h[HIW'(int'(r_k) * N_PU + j)]
                          * r_w2[W2AW'(int'(r_n) * N_HID + int'(r_k) * N_PU + j)];
            end
            w_sum = w_sum + ACC_W'(w_prod[j]);
        end
    end

    always_comb begin
        w_pre = PW'(r_acc) + (PW'(r_b1[r_n[HIW-1:0]]) <<< SHIFT);
`ifdef MLP_ROUND_EN
        w_pre = w_pre + RND;
`endif
        w_shr = w_pre >>> SHIFT;
        if (w_pre[PW-1]) begin
            w_hq = '0;
        end else if (w_shr > H_MAX) begin
            w_hq = H_MAX[DW-1:0];
        end else begin
            w_hq = w_shr[DW-1:0];
        end
        w_score = SW'(r_acc) + (SW'(r_b2[r_n[RW-1:0]]) <<< SHIFT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_k        <= '0;
            r_n        <= '0;
            r_acc      <= '0;
            r_best     <= '0;
            r_best_idx <= '0;
            r_busy     <= 1'b0;
            r_finish   <= 1'b0;
            r_result   <= '0;
        end else begin
            r_finish <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_L1_MAC;
                        r_busy  <= 1'b1;
                        r_acc   <= '0;
                        r_n     <= '0;
                        r_k     <= '0;
                    end
                end
                S_L1_MAC: begin
                    r_acc <= r_acc + w_sum;
                    if (r_k == K1_LAST) begin
                        r_k     <= '0;
                        r_state <= S_L1_WB;
                    end else begin
                        r_k <= r_k + KW'(1);
                    end
                end
                S_L1_WB: begin
                    r_acc <= '0;
                    if (r_n == HID_LAST) begin
                        r_n     <= '0;
                        r_state <= S_L2_MAC;
                    end else begin
                        r_n     <= r_n + CW'(1);
                        r_state <= S_L1_MAC;
                    end
                end
                S_L2_MAC: begin
                    r_acc <= r_acc + w_sum;
                    if (r_k == K2_LAST) begin
                        r_k     <= '0;
                        r_state <= S_L2_WB;
                    end else begin
                        r_k <= r_k + KW'(1);
                    end
                end
                S_L2_WB: begin
                    r_acc <= '0;
                    // Strict compare keeps the lowest index on ties.
                    if (r_n == '0 || w_score > r_best) begin
                        r_best     <= w_score;
                        r_best_idx <= r_n[RW-1:0];
                    end
                    if (r_n == OUT_LAST) begin
                        r_state <= S_DONE;
                    end else begin
                        r_n     <= r_n + CW'(1);
                        r_state <= S_L2_MAC;
                    end
                end
                S_DONE: begin
                    r_result <= r_best_idx;
                    r_finish <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
